// File: rtl/neuron_train_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// neuron_train_scheduler_pkg
// Shared types for the training scheduler of one neuron_learn layer:
//   zero2one_t    - fixed-point value in [0,1] carried on every layer lane
//   err_t         - per-sample error sum, wide enough for 35 lanes of
//                   |zero2one_t - zero2one_t| without overflow. Instances with
//                   a larger M need a wider type.
//   train_state_t - scheduler FSM encoding
//   abs_diff()    - unsigned |a-b| in zero2one_t width
// -----------------------------------------------------------------------------
package neuron_train_scheduler_pkg;

   typedef logic [7:0] zero2one_t;

   localparam int unsigned ERR_M_MAX = 35;

   typedef logic [$bits(zero2one_t)+$clog2(ERR_M_MAX+1)-1:0] err_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INFER,
      ST_SCORE,
      ST_DECIDE,
      ST_LEARN,
      ST_REPORT
   } train_state_t;

   function automatic zero2one_t abs_diff(input zero2one_t a, input zero2one_t b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/neuron_train_scheduler_abs_err_acc.sv
// -----------------------------------------------------------------------------
// zero2one_abs_err_acc
// One-cycle registered accumulator of |a-b|.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : zero the sum at the next edge (wins over enable)
//   enable       : add |a-b| to the sum at the next edge
//   a, b         : operands, one lane per cycle
//   acc          : running sum
// -----------------------------------------------------------------------------
module zero2one_abs_err_acc
   import neuron_train_scheduler_pkg::*;
(
   input  logic      clock,
   input  logic      reset,
   input  logic      clear,
   input  logic      enable,
   input  zero2one_t a,
   input  zero2one_t b,
   output err_t      acc
);

   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (enable) begin
         acc <= acc + err_t'(abs_diff(a, b));
      end
   end

endmodule

// File: rtl/neuron_train_scheduler.sv
// -----------------------------------------------------------------------------
// neuron_train_scheduler
// Sequencer for one neuron_learn layer: capture a sample, pulse inference,
// score the layer output one neuron per cycle, optionally run a learn phase,
// and report the error plus epoch bookkeeping.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   s_valid/s_ready       : sample handshake (ready only in IDLE)
//   s_in, s_target, s_last: sample features, expected outputs, epoch marker
//   learn_enable          : global learn gate (used in DECIDE)
//   err_threshold         : learn only when error is strictly above this
//   layer_valid/learn     : layer strobes
//   layer_in/expected_out : held copies of the captured sample
//   layer_out             : layer result
//   r_valid/r_ready       : result handshake
//   r_err, r_learned, r_epoch, r_epoch_end : registered per-sample result
// -----------------------------------------------------------------------------
module neuron_train_scheduler
   import neuron_train_scheduler_pkg::*;
#(
   parameter int N            = 16,
   parameter int M            = 35,
   parameter int INFER_LAT    = 2,
   parameter int LEARN_CYCLES = 3,
   parameter int EPOCH_W      = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  zero2one_t [N-1:0]     s_in,
   input  zero2one_t [M-1:0]     s_target,
   input  logic                  s_last,
   input  logic                  learn_enable,
   input  err_t                  err_threshold,
   output logic                  layer_valid,
   output logic                  layer_learn,
   output zero2one_t [N-1:0]     layer_in,
   output zero2one_t [M-1:0]     layer_expected_out,
   input  zero2one_t [M-1:0]     layer_out,
   output logic                  r_valid,
   input  logic                  r_ready,
   output err_t                  r_err,
   output logic                  r_learned,
   output logic [EPOCH_W-1:0]    r_epoch,
   output logic                  r_epoch_end
);

   localparam int PH_MAX = (INFER_LAT > LEARN_CYCLES) ? INFER_LAT : LEARN_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int IDX_W  = (M > 1) ? $clog2(M) : 1;

   train_state_t       state, state_next;
   logic [PH_W-1:0]    phase;
   logic [IDX_W-1:0]   idx;
   logic [EPOCH_W-1:0] epoch;
   logic               last_q;
   logic               learned;
   err_t               acc;
   logic               capture;
   logic               learn_go;
   logic               acc_clear;
   logic               acc_en;

   zero2one_abs_err_acc u_acc (
      .clock  (clock),
      .reset  (reset),
      .clear  (acc_clear),
      .enable (acc_en),
      .a      (layer_out[idx]),
      .b      (layer_expected_out[idx]),
      .acc    (acc)
   );

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_next  = state;
      s_ready     = 1'b0;
      layer_valid = 1'b0;
      layer_learn = 1'b0;
      r_valid     = 1'b0;
      capture     = 1'b0;
      acc_clear   = 1'b0;
      acc_en      = 1'b0;
      learn_go    = learn_enable && (acc > err_threshold);

      case (state)
         ST_IDLE: begin
            s_ready = 1'b1;
            if (s_valid) begin
               capture    = 1'b1;
               state_next = ST_INFER;
            end
         end
         ST_INFER: begin
            layer_valid = (phase == '0);
            if (phase == PH_W'(INFER_LAT - 1)) begin
               acc_clear  = 1'b1;
               state_next = ST_SCORE;
            end
         end
         ST_SCORE: begin
            acc_en = 1'b1;
            if (idx == IDX_W'(M - 1)) state_next = ST_DECIDE;
         end
         ST_DECIDE: begin
            state_next = learn_go ? ST_LEARN : ST_REPORT;
         end
         ST_LEARN: begin
            layer_valid = 1'b1;
            layer_learn = 1'b1;
            if (phase == PH_W'(LEARN_CYCLES - 1)) state_next = ST_REPORT;
         end
         ST_REPORT: begin
            r_valid = 1'b1;
            if (r_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // NOTE: the held sample registers are wide but still get an explicit reset,
   // since the layer sees them directly and must start from a known all-zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         state              <= ST_IDLE;
         phase              <= '0;
         idx                <= '0;
         epoch              <= '0;
         last_q             <= 1'b0;
         learned            <= 1'b0;
         layer_in           <= '0;
         layer_expected_out <= '0;
         r_err              <= '0;
         r_learned          <= 1'b0;
         r_epoch            <= '0;
         r_epoch_end        <= 1'b0;
      end else begin
         state <= state_next;

         // Phase counts only inside the timed states and restarts on any move.
         if ((state == ST_INFER || state == ST_LEARN) && state_next == state)
            phase <= phase + 1'b1;
         else
            phase <= '0;

         if (state == ST_SCORE && state_next == ST_SCORE)
            idx <= idx + 1'b1;
         else
            idx <= '0;

         if (capture) begin
            layer_in           <= s_in;
            layer_expected_out <= s_target;
            last_q             <= s_last;
            learned            <= 1'b0;
         end else if (state == ST_DECIDE && learn_go) begin
            learned <= 1'b1;
         end

         // Result fields are frozen on REPORT entry so back-pressure sees them stable.
         if (state_next == ST_REPORT && state != ST_REPORT) begin
            r_err       <= acc;
            r_learned   <= learned;
            r_epoch     <= epoch;
            r_epoch_end <= last_q;
         end

         if (state == ST_REPORT && r_ready && last_q)
            epoch <= epoch + 1'b1;
      end
   end

endmodule

// File: tb/tb_neuron_train_scheduler.sv
module tb_neuron_train_scheduler;
   import neuron_train_scheduler_pkg::*;

   localparam int N       = 16;
   localparam int M       = 35;
   localparam int EPOCH_W = 2;

   logic               clock, reset;
   logic               s_valid, s_ready, s_last, learn_enable;
   zero2one_t [N-1:0]  s_in, layer_in;
   zero2one_t [M-1:0]  s_target, layer_expected_out, layer_out;
   err_t               err_threshold, r_err;
   logic               layer_valid, layer_learn;
   logic               r_valid, r_ready, r_learned, r_epoch_end;
   logic [EPOCH_W-1:0] r_epoch;
   zero2one_t          stub_val;

   int passed = 0;
   int total  = 0;

   assign layer_out = {M{stub_val}};

   neuron_train_scheduler #(
      .N(N), .M(M), .INFER_LAT(2), .LEARN_CYCLES(3), .EPOCH_W(EPOCH_W)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .s_valid            (s_valid),
      .s_ready            (s_ready),
      .s_in               (s_in),
      .s_target           (s_target),
      .s_last             (s_last),
      .learn_enable       (learn_enable),
      .err_threshold      (err_threshold),
      .layer_valid        (layer_valid),
      .layer_learn        (layer_learn),
      .layer_in           (layer_in),
      .layer_expected_out (layer_expected_out),
      .layer_out          (layer_out),
      .r_valid            (r_valid),
      .r_ready            (r_ready),
      .r_err              (r_err),
      .r_learned          (r_learned),
      .r_epoch            (r_epoch),
      .r_epoch_end        (r_epoch_end)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Starts and ends on a negedge. Offers one uniform sample, then counts
   // cycles after the capture edge until r_valid (bounded at 100 cycles).
   task automatic run_sample(input zero2one_t in_v, input zero2one_t tgt_v,
                             input logic last, input err_t thr, input logic len,
                             output int rv_cycle, output int first_valid,
                             output int n_valid, output int n_learn);
      s_in          = {N{in_v}};
      s_target      = {M{tgt_v}};
      stub_val      = in_v;
      s_last        = last;
      err_threshold = thr;
      learn_enable  = len;
      r_ready       = 1'b0;
      s_valid       = 1'b1;
      rv_cycle = -1; first_valid = -1; n_valid = 0; n_learn = 0;
      for (int j = 1; j <= 100; j++) begin
         @(negedge clock);
         if (j == 1) s_valid = 1'b0;
         if (layer_valid) begin
            n_valid++;
            if (first_valid < 0) first_valid = j;
         end
         if (layer_learn) n_learn++;
         if (r_valid) begin
            rv_cycle = j;
            break;
         end
      end
   endtask

   task automatic handshake();
      r_ready = 1'b1;
      @(negedge clock);
      r_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      total++; if (s_ready !== 1'b1) $display("FAIL rst_s_ready: got %0b exp 1", s_ready); else passed++;
      total++; if (layer_valid !== 1'b0) $display("FAIL rst_layer_valid: got %0b exp 0", layer_valid); else passed++;
      total++; if (layer_learn !== 1'b0) $display("FAIL rst_layer_learn: got %0b exp 0", layer_learn); else passed++;
      total++; if (layer_in !== '0) $display("FAIL rst_layer_in: got %0h exp 0", layer_in); else passed++;
      total++; if (layer_expected_out !== '0) $display("FAIL rst_layer_exp: got %0h exp 0", layer_expected_out); else passed++;
      total++; if (r_valid !== 1'b0) $display("FAIL rst_r_valid: got %0b exp 0", r_valid); else passed++;
      total++; if (r_err !== '0) $display("FAIL rst_r_err: got %0d exp 0", r_err); else passed++;
      total++; if (r_learned !== 1'b0) $display("FAIL rst_r_learned: got %0b exp 0", r_learned); else passed++;
      total++; if (r_epoch !== '0) $display("FAIL rst_r_epoch: got %0d exp 0", r_epoch); else passed++;
      total++; if (r_epoch_end !== 1'b0) $display("FAIL rst_r_epoch_end: got %0b exp 0", r_epoch_end); else passed++;
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_below_threshold();
      int rv, fv, nv, nl;
      zero2one_t [N-1:0] exp_in;
      exp_in = {N{8'd4}};
      run_sample(8'd4, 8'd0, 1'b0, err_t'(200), 1'b1, rv, fv, nv, nl);
      total++; if (rv !== 39) $display("FAIL below_rvalid_cycle: got %0d exp 39", rv); else passed++;
      total++; if (fv !== 1) $display("FAIL below_first_valid: got %0d exp 1", fv); else passed++;
      total++; if (nv !== 1) $display("FAIL below_valid_cycles: got %0d exp 1", nv); else passed++;
      total++; if (nl !== 0) $display("FAIL below_learn_cycles: got %0d exp 0", nl); else passed++;
      total++; if (r_err !== err_t'(140)) $display("FAIL below_err: got %0d exp 140", r_err); else passed++;
      total++; if (r_learned !== 1'b0) $display("FAIL below_learned: got %0b exp 0", r_learned); else passed++;
      total++; if (layer_in !== exp_in) $display("FAIL below_layer_in: got %0h exp %0h", layer_in, exp_in); else passed++;
      handshake();
      total++; if (s_ready !== 1'b1) $display("FAIL below_ready_after: got %0b exp 1", s_ready); else passed++;
   endtask

   task automatic test_above_threshold();
      int rv, fv, nv, nl;
      run_sample(8'd4, 8'd0, 1'b0, err_t'(139), 1'b1, rv, fv, nv, nl);
      total++; if (rv !== 42) $display("FAIL above_rvalid_cycle: got %0d exp 42", rv); else passed++;
      total++; if (nl !== 3) $display("FAIL above_learn_cycles: got %0d exp 3", nl); else passed++;
      total++; if (nv !== 4) $display("FAIL above_valid_cycles: got %0d exp 4", nv); else passed++;
      total++; if (r_err !== err_t'(140)) $display("FAIL above_err: got %0d exp 140", r_err); else passed++;
      total++; if (r_learned !== 1'b1) $display("FAIL above_learned: got %0b exp 1", r_learned); else passed++;
      handshake();
   endtask

   task automatic test_equal_and_gate();
      int rv, fv, nv, nl;
      run_sample(8'd4, 8'd0, 1'b0, err_t'(140), 1'b1, rv, fv, nv, nl);
      total++; if (nl !== 0) $display("FAIL equal_learn_cycles: got %0d exp 0", nl); else passed++;
      total++; if (r_learned !== 1'b0) $display("FAIL equal_learned: got %0b exp 0", r_learned); else passed++;
      total++; if (rv !== 39) $display("FAIL equal_rvalid_cycle: got %0d exp 39", rv); else passed++;
      handshake();
      run_sample(8'd4, 8'd0, 1'b0, err_t'(0), 1'b0, rv, fv, nv, nl);
      total++; if (nl !== 0) $display("FAIL gate_learn_cycles: got %0d exp 0", nl); else passed++;
      total++; if (r_learned !== 1'b0) $display("FAIL gate_learned: got %0b exp 0", r_learned); else passed++;
      total++; if (rv !== 39) $display("FAIL gate_rvalid_cycle: got %0d exp 39", rv); else passed++;
      handshake();
   endtask

   task automatic test_abs_direction();
      int rv, fv, nv, nl;
      // target above output: |4-10| = 6 per lane -> 210
      run_sample(8'd4, 8'd10, 1'b0, err_t'(1000), 1'b1, rv, fv, nv, nl);
      total++; if (r_err !== err_t'(210)) $display("FAIL absdir_err: got %0d exp 210", r_err); else passed++;
      total++; if (r_learned !== 1'b0) $display("FAIL absdir_learned: got %0b exp 0", r_learned); else passed++;
      handshake();
      // large error: 200 per lane -> 7000, just above threshold 6999
      run_sample(8'd200, 8'd0, 1'b0, err_t'(6999), 1'b1, rv, fv, nv, nl);
      total++; if (r_err !== err_t'(7000)) $display("FAIL big_err: got %0d exp 7000", r_err); else passed++;
      total++; if (r_learned !== 1'b1) $display("FAIL big_learned: got %0b exp 1", r_learned); else passed++;
      total++; if (rv !== 42) $display("FAIL big_rvalid_cycle: got %0d exp 42", rv); else passed++;
      handshake();
   endtask

   task automatic test_backpressure();
      int rv, fv, nv, nl;
      zero2one_t [N-1:0] exp_in;
      int bad_valid, bad_err, bad_ready;
      exp_in = {N{8'd7}};
      // |7-3| = 4 per lane -> 140
      run_sample(8'd7, 8'd3, 1'b0, err_t'(500), 1'b1, rv, fv, nv, nl);
      total++; if (r_err !== err_t'(140)) $display("FAIL bp_err: got %0d exp 140", r_err); else passed++;
      bad_valid = 0; bad_err = 0; bad_ready = 0;
      s_valid = 1'b1;
      s_in    = {N{8'hAA}};
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         if (r_valid !== 1'b1) bad_valid++;
         if (r_err !== err_t'(140)) bad_err++;
         if (s_ready !== 1'b0) bad_ready++;
      end
      s_valid = 1'b0;
      total++; if (bad_valid != 0) $display("FAIL bp_r_valid_hold: got %0d drops exp 0", bad_valid); else passed++;
      total++; if (bad_err != 0) $display("FAIL bp_r_err_hold: got %0d changes exp 0", bad_err); else passed++;
      total++; if (bad_ready != 0) $display("FAIL bp_s_ready_low: got %0d highs exp 0", bad_ready); else passed++;
      total++; if (layer_in !== exp_in) $display("FAIL bp_no_capture: got %0h exp %0h", layer_in, exp_in); else passed++;
      handshake();
      total++; if (s_ready !== 1'b1) $display("FAIL bp_ready_after: got %0b exp 1", s_ready); else passed++;
      total++; if (r_valid !== 1'b0) $display("FAIL bp_r_valid_after: got %0b exp 0", r_valid); else passed++;
      total++; if (layer_in !== exp_in) $display("FAIL bp_layer_in_hold: got %0h exp %0h", layer_in, exp_in); else passed++;
   endtask

   task automatic test_epoch();
      int rv, fv, nv, nl;
      logic lasts [7]     = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      int   exp_epoch [7] = '{0, 0, 0, 1, 2, 3, 0};
      for (int s = 0; s < 7; s++) begin
         run_sample(8'd1, 8'd1, lasts[s], err_t'(0), 1'b1, rv, fv, nv, nl);
         total++; if (int'(r_epoch) != exp_epoch[s]) $display("FAIL epoch_s%0d: got %0d exp %0d", s, r_epoch, exp_epoch[s]); else passed++;
         total++; if (r_epoch_end !== lasts[s]) $display("FAIL epoch_end_s%0d: got %0b exp %0b", s, r_epoch_end, lasts[s]); else passed++;
         handshake();
      end
   endtask

   task automatic test_reset_mid();
      int rv, fv, nv, nl;
      int seen_rvalid;
      zero2one_t [N-1:0] exp_in;
      for (int pass = 0; pass < 2; pass++) begin
         s_in = {N{8'd4}}; s_target = {M{8'd0}}; stub_val = 8'd4;
         s_last = 1'b0; err_threshold = err_t'(139); learn_enable = 1'b1;
         s_valid = 1'b1;
         // SCORE k=10 is cycle T+13; LEARN second cycle is T+40
         for (int j = 1; j <= ((pass == 0) ? 13 : 40); j++) begin
            @(negedge clock);
            if (j == 1) s_valid = 1'b0;
         end
         if (pass == 1) begin
            total++; if (layer_learn !== 1'b1) $display("FAIL mid_in_learn: got %0b exp 1", layer_learn); else passed++;
         end
         reset = 1'b1;
         @(negedge clock);
         reset = 1'b0;
         total++; if (s_ready !== 1'b1) $display("FAIL mid%0d_s_ready: got %0b exp 1", pass, s_ready); else passed++;
         total++; if (layer_valid !== 1'b0 || layer_learn !== 1'b0) $display("FAIL mid%0d_strobes: got %0b%0b exp 00", pass, layer_valid, layer_learn); else passed++;
         total++; if (layer_in !== '0 || layer_expected_out !== '0) $display("FAIL mid%0d_layer_data: got %0h exp 0", pass, layer_in); else passed++;
         total++; if (r_valid !== 1'b0 || r_err !== '0 || r_epoch !== '0) $display("FAIL mid%0d_result: got v%0b e%0d ep%0d exp 0", pass, r_valid, r_err, r_epoch); else passed++;
      end
      seen_rvalid = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clock);
         if (r_valid) seen_rvalid++;
      end
      total++; if (seen_rvalid != 0) $display("FAIL mid_discarded: got %0d r_valid cycles exp 0", seen_rvalid); else passed++;
      // |9-2| = 7 per lane -> 245
      exp_in = {N{8'd9}};
      run_sample(8'd9, 8'd2, 1'b0, err_t'(1000), 1'b1, rv, fv, nv, nl);
      total++; if (rv !== 39) $display("FAIL fresh_rvalid_cycle: got %0d exp 39", rv); else passed++;
      total++; if (r_err !== err_t'(245)) $display("FAIL fresh_err: got %0d exp 245", r_err); else passed++;
      total++; if (r_epoch !== '0) $display("FAIL fresh_epoch: got %0d exp 0", r_epoch); else passed++;
      total++; if (layer_in !== exp_in) $display("FAIL fresh_layer_in: got %0h exp %0h", layer_in, exp_in); else passed++;
      handshake();
   endtask

   initial begin
      reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; learn_enable = 1'b0;
      err_threshold = '0; r_ready = 1'b0; s_in = '0; s_target = '0; stub_val = '0;
      @(negedge clock);
      test_reset();
      test_below_threshold();
      test_above_threshold();
      test_equal_and_gate();
      test_abs_direction();
      test_backpressure();
      test_epoch();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
